// File: rtl/controle_chamadas_pkg.sv
// Shared types and defaults for the elevator call scheduler.
package elevador_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    PORTA    = 2'd3
  } estado_t;

  localparam int unsigned NUM_ANDARES_PAD   = 4;
  localparam int unsigned LARG_ANDAR_PAD    = 2;
  localparam int unsigned TEMPO_PORTA_PAD   = 3;
  localparam int unsigned SYNC_ESTAGIOS_PAD = 2;

  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;

  // Next state after the door closes: keep the previous direction if calls remain ahead.
  function automatic estado_t apos_porta(input logic dir, input logic acima, input logic abaixo);
    estado_t prox;
    prox = PARADO;
    if (dir == SOBE) begin
      if (acima)       prox = SUBINDO;
      else if (abaixo) prox = DESCENDO;
    end else begin
      if (abaixo)      prox = DESCENDO;
      else if (acima)  prox = SUBINDO;
    end
    return prox;
  endfunction

endpackage

// File: rtl/controle_chamadas_if.sv
// Scheduler <-> floor-controller/board bundle; ELEVADOR_EMERGENCIA_EN adds parar_emerg.
interface controle_chamadas_if
  import elevador_pkg::*;
#(
  parameter int unsigned NUM_ANDARES = NUM_ANDARES_PAD,
  parameter int unsigned LARG_ANDAR  = LARG_ANDAR_PAD
);
  logic                   tick;
  logic [NUM_ANDARES-1:0] botoes;
  logic [LARG_ANDAR-1:0]  andar_atual;
  logic                   sub_des;
  logic                   mover;
  logic                   porta_aberta;
  logic [NUM_ANDARES-1:0] chamadas_pend;
`ifdef ELEVADOR_EMERGENCIA_EN
  logic                   parar_emerg;

  modport master (output tick, botoes, andar_atual, parar_emerg,
                  input  sub_des, mover, porta_aberta, chamadas_pend);
  modport slave  (input  tick, botoes, andar_atual, parar_emerg,
                  output sub_des, mover, porta_aberta, chamadas_pend);
`else
  modport master (output tick, botoes, andar_atual,
                  input  sub_des, mover, porta_aberta, chamadas_pend);
  modport slave  (input  tick, botoes, andar_atual,
                  output sub_des, mover, porta_aberta, chamadas_pend);
`endif
endinterface

// File: rtl/controle_chamadas_sincroniza_botao.sv
// Button synchronizer followed by a rising-edge detector; pulso is one cycle wide.
module sincroniza_botao #(
  parameter int unsigned SYNC_ESTAGIOS = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic entrada,
  output logic pulso
);
  logic [SYNC_ESTAGIOS-1:0] sync_q, sync_d;
  logic                     anterior_q, anterior_d;

  always_comb begin
    sync_d     = (sync_q << 1) | SYNC_ESTAGIOS'(entrada);
    anterior_d = sync_q[SYNC_ESTAGIOS-1];
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      anterior_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      anterior_q <= anterior_d;
    end
  end

  assign pulso = sync_q[SYNC_ESTAGIOS-1] & ~anterior_q;

endmodule

// File: rtl/controle_chamadas.sv
// SCAN call scheduler feeding controle_andares; ELEVADOR_EMERGENCIA_EN enables the emergency stop.
module controle_chamadas
  import elevador_pkg::*;
#(
  parameter int unsigned NUM_ANDARES   = NUM_ANDARES_PAD,
  parameter int unsigned LARG_ANDAR    = LARG_ANDAR_PAD,
  parameter int unsigned TEMPO_PORTA   = TEMPO_PORTA_PAD,
  parameter int unsigned SYNC_ESTAGIOS = SYNC_ESTAGIOS_PAD
) (
  input  logic                clock_in,
  input  logic                reset_n,
  controle_chamadas_if.slave  bus
);
  localparam int unsigned          LARG_CNT = $clog2(TEMPO_PORTA + 1);
  localparam logic [LARG_CNT-1:0]  CNT_CARGA = LARG_CNT'(TEMPO_PORTA);
  localparam logic [LARG_ANDAR-1:0] TOPO    = LARG_ANDAR'(NUM_ANDARES - 1);

  estado_t                state_q, state_d;
  logic                   sub_des_q, sub_des_d;
  logic                   mover_q, mover_d;
  logic                   porta_q, porta_d;
  logic [NUM_ANDARES-1:0] pend_q, pend_d;
  logic [LARG_CNT-1:0]    cnt_q, cnt_d;

  logic [NUM_ANDARES-1:0] pulsos, novos, mascara;
  logic                   aqui, acima, abaixo, novo_aqui;
  logic                   emerg;

  for (genvar k = 0; k < NUM_ANDARES; k++) begin : g_sync
    sincroniza_botao #(.SYNC_ESTAGIOS(SYNC_ESTAGIOS)) u_sync (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .entrada  (bus.botoes[k]),
      .pulso    (pulsos[k])
    );
  end

`ifdef ELEVADOR_EMERGENCIA_EN
  logic [SYNC_ESTAGIOS-1:0] emerg_q, emerg_d;

  always_comb emerg_d = (emerg_q << 1) | SYNC_ESTAGIOS'(bus.parar_emerg);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) emerg_q <= '0;
    else          emerg_q <= emerg_d;
  end

  assign emerg = emerg_q[SYNC_ESTAGIOS-1];
`else
  assign emerg = 1'b0;
`endif

  // Presses are dropped entirely while the emergency stop holds.
  assign novos = emerg ? '0 : pulsos;

  // Position of pending calls and new presses relative to the current floor.
  always_comb begin
    aqui      = 1'b0;
    acima     = 1'b0;
    abaixo    = 1'b0;
    novo_aqui = 1'b0;
    mascara   = '0;
    for (int i = 0; i < NUM_ANDARES; i++) begin
      if (LARG_ANDAR'(i) == bus.andar_atual) begin
        aqui       = pend_q[i];
        novo_aqui  = novos[i];
        mascara[i] = 1'b1;
      end else if (LARG_ANDAR'(i) > bus.andar_atual) begin
        acima = acima | pend_q[i];
      end else begin
        abaixo = abaixo | pend_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sub_des_d = sub_des_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q | novos;

    case (state_q)
      PARADO: begin
        if (aqui)        state_d = PORTA;
        else if (acima)  state_d = SUBINDO;
        else if (abaixo) state_d = DESCENDO;
      end
      SUBINDO: begin
        if (aqui)                                    state_d = PORTA;
        else if (bus.andar_atual == TOPO || !acima)  state_d = PARADO;
      end
      DESCENDO: begin
        if (aqui)                                    state_d = PORTA;
        else if (bus.andar_atual == '0 || !abaixo)   state_d = PARADO;
      end
      PORTA: begin
        // A press at the open floor keeps the door open instead of queuing a call.
        pend_d = pend_q | (novos & ~mascara);
        if (novo_aqui) begin
          cnt_d = CNT_CARGA;
        end else if (bus.tick) begin
          if (cnt_q <= LARG_CNT'(1)) begin
            cnt_d   = '0;
            state_d = apos_porta(sub_des_q, acima, abaixo);
          end else begin
            cnt_d = cnt_q - LARG_CNT'(1);
          end
        end
      end
      default: state_d = PARADO;
    endcase

    if (state_d == PORTA && state_q != PORTA) begin
      pend_d = (pend_q & ~mascara) | novos;
      cnt_d  = CNT_CARGA;
    end
    if (state_d == SUBINDO && state_q != SUBINDO)   sub_des_d = SOBE;
    if (state_d == DESCENDO && state_q != DESCENDO) sub_des_d = DESCE;

    if (emerg) begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sub_des_d = sub_des_q;
      pend_d    = pend_q;
    end

    mover_d = !emerg && (state_d == SUBINDO || state_d == DESCENDO);
    porta_d = !emerg && (state_d == PORTA);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PARADO;
      sub_des_q <= SOBE;
      mover_q   <= 1'b0;
      porta_q   <= 1'b0;
      pend_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sub_des_q <= sub_des_d;
      mover_q   <= mover_d;
      porta_q   <= porta_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.sub_des       = sub_des_q;
  assign bus.mover         = mover_q;
  assign bus.porta_aberta  = porta_q;
  assign bus.chamadas_pend = pend_q;

endmodule
